rgb_frame_capture: RTL and testbench

RGB_FRAME_CAPTURE -- requirements
Module: rgb_frame_capture

---
 rtl/rgb_frame_capture.sv | 237 +++++++++++++++++++++++
 tb/tb_rgb_frame_capture.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_capture.sv
// rgb_frame_capture: binarises an RGB565 video stream inside a fixed capture
// window and streams one bit per pixel into a frame buffer.
// Optional feature macro: CAPTURE_MEASURE_EN (frame timing measurement on
// MEAS_W / MEAS_H / LINE_ERR); when undefined those outputs are tied to 0.
module rgb_frame_capture #(
  parameter int unsigned IMG_W  = 630,
  parameter int unsigned IMG_H  = 390,
  parameter int unsigned X_OFS  = 85,
  parameter int unsigned Y_OFS  = 45,
  parameter logic [7:0]  THRESH = 8'd78
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        ENABLE,
  input  logic        VID_DE,
  input  logic        VID_HSYNC,
  input  logic        VID_VSYNC,
  input  logic [4:0]  VID_R,
  input  logic [5:0]  VID_G,
  input  logic [4:0]  VID_B,
  output logic        WR_EN,
  output logic [17:0] WR_ADDR,
  output logic        WR_DATA,
  output logic        FRAME_DONE,
  output logic [10:0] MEAS_W,
  output logic [10:0] MEAS_H,
  output logic        LINE_ERR
);

  localparam int unsigned CntW   = 11;
  localparam int unsigned AddrW  = 18;
  localparam int unsigned ColEnd = X_OFS + IMG_W;
  localparam int unsigned RowEnd = Y_OFS + IMG_H;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic {
    WAIT_VS = 1'b0,
    CAPTURE = 1'b1
  } stateT;

  stateT stateQ;
  stateT stateNext;

  // stage 1 registered video inputs
  logic       deR;
  logic       hsR;
  logic       vsR;
  logic       vsPrev;
  logic       dePrev;
  logic [4:0] rR;
  logic [5:0] gR;
  logic [4:0] bR;

  logic frameStart;
  logic deFall;
  logic frameDoneC;
  logic inWinC;
  logic [7:0] lumaC;

  logic [CntW-1:0]  col;
  logic [CntW-1:0]  row;
  logic [AddrW-1:0] addrCnt;

  // stage 2 write decision
  logic             hitQ;
  logic             bitQ;
  logic [AddrW-1:0] addrQ;

  // HSYNC is registered with the rest of the timing but line framing uses DE
  logic unusedHsync;
  assign unusedHsync = hsR;

  // Register all incoming video signals once and keep delayed copies for edges
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      deR    <= 1'b0;
      hsR    <= 1'b0;
      vsR    <= 1'b0;
      vsPrev <= 1'b0;
      dePrev <= 1'b0;
      rR     <= '0;
      gR     <= '0;
      bR     <= '0;
    end else begin
      deR    <= VID_DE;
      hsR    <= VID_HSYNC;
      vsR    <= VID_VSYNC;
      vsPrev <= vsR;
      dePrev <= deR;
      rR     <= VID_R;
      gR     <= VID_G;
      bR     <= VID_B;
    end
  end

  assign frameStart = vsPrev & ~vsR;
  assign deFall     = dePrev & ~deR;

  // State register
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      stateQ <= WAIT_VS;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Next state and end-of-frame detection
  always_comb begin
    stateNext  = stateQ;
    frameDoneC = 1'b0;
    case (stateQ)
      WAIT_VS: begin
        if (frameStart && ENABLE) begin
          stateNext = CAPTURE;
        end
      end
      CAPTURE: begin
        if (frameStart) begin
          frameDoneC = 1'b1;
          if (!ENABLE) begin
            stateNext = WAIT_VS;
          end
        end
      end
      default: stateNext = WAIT_VS;
    endcase
  end

  // Registered frame-done pulse
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= frameDoneC;
    end
  end

  // Column/row position counters, saturating, cleared at frame start
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      col <= '0;
      row <= '0;
    end else if (frameStart) begin
      col <= '0;
      row <= '0;
    end else begin
      if (deR) begin
        col <= (col == CntMax) ? col : col + CntW'(1);
      end else begin
        col <= '0;
      end
      if (deFall && (row != CntMax)) begin
        row <= row + CntW'(1);
      end
    end
  end

  assign lumaC  = 8'({rR, 1'b0}) + 8'(gR) + 8'(bR);
  assign inWinC = (stateQ == CAPTURE) && deR && !frameStart &&
                  (32'(col) >= X_OFS) && (32'(col) < ColEnd) &&
                  (32'(row) >= Y_OFS) && (32'(row) < RowEnd);

  // Stage 2: window hit, binarised pixel and incrementing write address
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      hitQ    <= 1'b0;
      bitQ    <= 1'b0;
      addrQ   <= '0;
      addrCnt <= '0;
    end else begin
      hitQ <= inWinC;
      if (frameStart) begin
        addrCnt <= '0;
      end else if (inWinC) begin
        bitQ    <= (lumaC >= THRESH);
        addrQ   <= addrCnt;
        addrCnt <= addrCnt + AddrW'(1);
      end
    end
  end

  // Stage 3: frame-buffer write port; address/data hold between writes
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      WR_EN   <= 1'b0;
      WR_ADDR <= '0;
      WR_DATA <= 1'b0;
    end else begin
      WR_EN <= hitQ;
      if (hitQ) begin
        WR_ADDR <= addrQ;
        WR_DATA <= bitQ;
      end
    end
  end

`ifdef CAPTURE_MEASURE_EN
  logic [CntW-1:0] firstLen;
  logic            errAcc;

  // Track first-line DE length and flag any line that differs from it
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      firstLen <= '0;
      errAcc   <= 1'b0;
    end else if (frameStart) begin
      firstLen <= '0;
      errAcc   <= 1'b0;
    end else if (deFall) begin
      if (row == '0) begin
        firstLen <= col;
      end else if (col != firstLen) begin
        errAcc <= 1'b1;
      end
    end
  end

  // Report the finished frame's measurements alongside FRAME_DONE
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      MEAS_W   <= '0;
      MEAS_H   <= '0;
      LINE_ERR <= 1'b0;
    end else if (frameDoneC) begin
      MEAS_W   <= firstLen;
      MEAS_H   <= row;
      LINE_ERR <= errAcc;
    end
  end
`else
  assign MEAS_W   = '0;
  assign MEAS_H   = '0;
  assign LINE_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_frame_capture.sv
// tb_rgb_frame_capture: scoreboard bench for rgb_frame_capture using a
// reduced capture window so whole frames stay short.
module tb_rgb_frame_capture;

  localparam int W   = 12;
  localparam int H   = 6;
  localparam int XO  = 5;
  localparam int YO  = 3;
  localparam int LW  = 24;
  localparam int NL  = 12;
  localparam int THR = 78;

  logic        PixelClk = 1'b0;
  logic        nRST = 1'b1;
  logic        ENABLE = 1'b0;
  logic        VID_DE = 1'b0;
  logic        VID_HSYNC = 1'b0;
  logic        VID_VSYNC = 1'b0;
  logic [4:0]  VID_R = '0;
  logic [5:0]  VID_G = '0;
  logic [4:0]  VID_B = '0;
  logic        WR_EN;
  logic [17:0] WR_ADDR;
  logic        WR_DATA;
  logic        FRAME_DONE;
  logic [10:0] MEAS_W;
  logic [10:0] MEAS_H;
  logic        LINE_ERR;

  typedef struct {
    logic [17:0] addr;
    logic        data;
    int          due;
  } expT;

  expT sbQ[$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int wrCount = 0;
  int onesCount = 0;
  int doneCount = 0;
  int expDone = 0;
  int expAddr = 0;
  bit monEn = 1'b0;
  bit modelCapt = 1'b0;
  bit prevDone = 1'b0;
  logic [17:0] lastAddr = '0;
  logic        lastData = 1'b0;
  int pendW = 0;
  int pendH = 0;
  bit pendErr = 1'b0;
  int expMeasW = 0;
  int expMeasH = 0;
  bit expLineErr = 1'b0;

  rgb_frame_capture #(
    .IMG_W (W),
    .IMG_H (H),
    .X_OFS (XO),
    .Y_OFS (YO)
  ) dut (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .ENABLE     (ENABLE),
    .VID_DE     (VID_DE),
    .VID_HSYNC  (VID_HSYNC),
    .VID_VSYNC  (VID_VSYNC),
    .VID_R      (VID_R),
    .VID_G      (VID_G),
    .VID_B      (VID_B),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .FRAME_DONE (FRAME_DONE),
    .MEAS_W     (MEAS_W),
    .MEAS_H     (MEAS_H),
    .LINE_ERR   (LINE_ERR)
  );

  always #5 PixelClk = ~PixelClk;

  always @(posedge PixelClk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on each write, checks hold and pulses
  always @(negedge PixelClk) begin
    if (!nRST) begin
      lastAddr = '0;
      lastData = 1'b0;
      prevDone = 1'b0;
    end else if (monEn) begin
      if (WR_EN) begin
        expT e;
        tests++;
        if (sbQ.size() == 0) begin
          failed++;
          $display("FAIL unexpected_write got addr=%0d data=%0d cyc=%0d", WR_ADDR, WR_DATA, cyc);
        end else begin
          e = sbQ.pop_front();
          if (WR_ADDR !== e.addr || WR_DATA !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL write got addr=%0d data=%0d cyc=%0d, want addr=%0d data=%0d cyc=%0d",
                     WR_ADDR, WR_DATA, cyc, e.addr, e.data, e.due);
          end
        end
        wrCount++;
        if (WR_DATA) onesCount++;
        lastAddr = WR_ADDR;
        lastData = WR_DATA;
      end else begin
        tests++;
        if (WR_ADDR !== lastAddr || WR_DATA !== lastData) begin
          failed++;
          $display("FAIL hold got addr=%0d data=%0d, want addr=%0d data=%0d",
                   WR_ADDR, WR_DATA, lastAddr, lastData);
        end
      end
      if (FRAME_DONE) begin
        doneCount++;
        tests++;
        if (prevDone) begin
          failed++;
          $display("FAIL done_width got a pulse longer than one cycle at cyc=%0d", cyc);
        end
        tests++;
        if (int'(MEAS_W) != expMeasW || int'(MEAS_H) != expMeasH || LINE_ERR !== expLineErr) begin
          failed++;
          $display("FAIL meas got w=%0d h=%0d err=%0d, want w=%0d h=%0d err=%0d",
                   MEAS_W, MEAS_H, LINE_ERR, expMeasW, expMeasH, expLineErr);
        end
      end
      prevDone = FRAME_DONE;
    end
  end

  task automatic step();
    @(posedge PixelClk);
    #1;
  endtask

  // Drives one frame; kind selects the pixel pattern, -1 disables options
  task automatic drive_frame(input int kind, input int lines, input int shortRow,
                             input int shortLen, input int dropRow, input int rstRow);
    bit capt;
    bit err;
    int len;
    int lum;
    int rstHold;
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    expT e;
    err = 1'b0;
    rstHold = 0;
    VID_DE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      VID_VSYNC = 1'b1;
    end
    step();
    VID_VSYNC = 1'b0;
    if (modelCapt) begin
      expDone++;
`ifdef CAPTURE_MEASURE_EN
      expMeasW = pendW;
      expMeasH = pendH;
      expLineErr = pendErr;
`endif
    end
    modelCapt = ENABLE;
    capt = modelCapt;
    expAddr = 0;
    for (int i = 0; i < 4; i++) step();
    for (int r = 0; r < lines; r++) begin
      len = (r == shortRow) ? shortLen : LW;
      if (len != LW) err = 1'b1;
      if (r == dropRow) ENABLE = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        VID_DE = 1'b0;
        VID_HSYNC = (i < 2);
        if (rstHold > 0) begin
          rstHold--;
          if (rstHold == 0) nRST = 1'b1;
        end
      end
      for (int c = 0; c < len; c++) begin
        step();
        if (rstHold > 0) begin
          rstHold--;
          if (rstHold == 0) nRST = 1'b1;
        end
        r5 = '0; g6 = '0; b5 = '0;
        case (kind)
          0: begin r5 = 5'd31; g6 = 6'd63; b5 = 5'd31; end
          1: if (r == YO && c == XO) begin r5 = 5'd20; g6 = 6'd40; b5 = 5'd0; end
          2: begin
            if (r == YO && c == XO)     begin r5 = 5'd0; g6 = 6'd46; b5 = 5'd31; end
            if (r == YO && c == XO + 1) begin r5 = 5'd1; g6 = 6'd45; b5 = 5'd31; end
          end
          default: begin
            r5 = 5'($urandom_range(0, 31));
            g6 = 6'($urandom_range(0, 63));
            b5 = 5'($urandom_range(0, 31));
          end
        endcase
        VID_DE = 1'b1;
        VID_HSYNC = 1'b0;
        VID_R = r5;
        VID_G = g6;
        VID_B = b5;
        if (r == rstRow && c == 9) begin
          nRST = 1'b0;
          #1;
          tests++;
          if (WR_EN !== 1'b0) begin failed++; $display("FAIL rst_wr_en got %0d want 0", WR_EN); end
          tests++;
          if (WR_ADDR !== 18'd0) begin failed++; $display("FAIL rst_wr_addr got %0d want 0", WR_ADDR); end
          tests++;
          if (WR_DATA !== 1'b0) begin failed++; $display("FAIL rst_wr_data got %0d want 0", WR_DATA); end
          tests++;
          if (FRAME_DONE !== 1'b0) begin failed++; $display("FAIL rst_done got %0d want 0", FRAME_DONE); end
          sbQ.delete();
          modelCapt = 1'b0;
          capt = 1'b0;
          rstHold = 2;
        end
        if (capt && r >= YO && r < YO + H && c >= XO && c < XO + W) begin
          lum = 2 * int'(r5) + int'(g6) + int'(b5);
          e.addr = 18'(expAddr);
          e.data = (lum >= THR);
          e.due = cyc + 3;
          sbQ.push_back(e);
          expAddr++;
        end
      end
    end
    step();
    VID_DE = 1'b0;
    for (int i = 0; i < 7; i++) step();
    pendW = LW;
    pendH = lines;
    pendErr = err;
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    tests++;
    if (WR_EN !== 1'b0) begin failed++; $display("FAIL reset_wr_en got %0d want 0", WR_EN); end
    tests++;
    if (WR_ADDR !== 18'd0) begin failed++; $display("FAIL reset_wr_addr got %0d want 0", WR_ADDR); end
    tests++;
    if (WR_DATA !== 1'b0) begin failed++; $display("FAIL reset_wr_data got %0d want 0", WR_DATA); end
    tests++;
    if (FRAME_DONE !== 1'b0) begin failed++; $display("FAIL reset_done got %0d want 0", FRAME_DONE); end
    tests++;
    if (MEAS_W !== 11'd0 || MEAS_H !== 11'd0 || LINE_ERR !== 1'b0) begin
      failed++;
      $display("FAIL reset_meas got w=%0d h=%0d err=%0d want 0", MEAS_W, MEAS_H, LINE_ERR);
    end
    repeat (3) step();
    nRST = 1'b1;
    monEn = 1'b1;
    step();
  endtask

  task automatic test_full_frames();
    int w0;
    ENABLE = 1'b1;
    w0 = wrCount;
    drive_frame(0, NL, -1, 0, -1, -1);
    tests++;
    if (wrCount - w0 != W * H) begin failed++; $display("FAIL full_f1_writes got %0d want %0d", wrCount - w0, W * H); end
    tests++;
    if (doneCount != 0) begin failed++; $display("FAIL first_start_done got %0d want 0", doneCount); end
    w0 = wrCount;
    drive_frame(0, NL, -1, 0, -1, -1);
    tests++;
    if (wrCount - w0 != W * H) begin failed++; $display("FAIL full_f2_writes got %0d want %0d", wrCount - w0, W * H); end
    tests++;
    if (doneCount != 1) begin failed++; $display("FAIL full_done got %0d want 1", doneCount); end
  endtask

  task automatic test_single_pixel();
    int o0;
    o0 = onesCount;
    drive_frame(1, NL, -1, 0, -1, -1);
    tests++;
    if (onesCount - o0 != 1) begin failed++; $display("FAIL single_ones got %0d want 1", onesCount - o0); end
  endtask

  task automatic test_threshold();
    int o0;
    o0 = onesCount;
    drive_frame(2, NL, -1, 0, -1, -1);
    tests++;
    if (onesCount - o0 != 1) begin failed++; $display("FAIL thresh_ones got %0d want 1", onesCount - o0); end
  endtask

  task automatic test_random();
    int w0;
    w0 = wrCount;
    drive_frame(3, NL, -1, 0, -1, -1);
    tests++;
    if (wrCount - w0 != W * H) begin failed++; $display("FAIL random_writes got %0d want %0d", wrCount - w0, W * H); end
  endtask

  task automatic test_enable_drop();
    int w0;
    int d0;
    w0 = wrCount;
    drive_frame(3, NL, -1, 0, YO + 2, -1);
    tests++;
    if (wrCount - w0 != W * H) begin failed++; $display("FAIL drop_writes got %0d want %0d", wrCount - w0, W * H); end
    w0 = wrCount;
    d0 = doneCount;
    drive_frame(0, NL, -1, 0, -1, -1);
    tests++;
    if (wrCount - w0 != 0) begin failed++; $display("FAIL idle_writes got %0d want 0", wrCount - w0); end
    tests++;
    if (doneCount - d0 != 1) begin failed++; $display("FAIL drop_done got %0d want 1", doneCount - d0); end
    ENABLE = 1'b1;
  endtask

  task automatic test_short_frame();
    int w0;
    int d0;
    w0 = wrCount;
    d0 = doneCount;
    drive_frame(0, YO + H - 2, YO + 1, XO + 3, -1, -1);
    tests++;
    if (wrCount - w0 != 3 * W + 3) begin failed++; $display("FAIL short_writes got %0d want %0d", wrCount - w0, 3 * W + 3); end
    tests++;
    if (doneCount - d0 != 0) begin failed++; $display("FAIL wait_vs_done got %0d want 0", doneCount - d0); end
  endtask

  task automatic test_line_err();
    int w0;
    w0 = wrCount;
    drive_frame(3, NL, 10, LW - 1, -1, -1);
    tests++;
    if (wrCount - w0 != W * H) begin failed++; $display("FAIL lineerr_writes got %0d want %0d", wrCount - w0, W * H); end
  endtask

  task automatic test_reset_mid();
    int w0;
    drive_frame(0, NL, -1, 0, -1, YO + 2);
    w0 = wrCount;
    drive_frame(3, NL, -1, 0, -1, -1);
    tests++;
    if (wrCount - w0 != W * H) begin failed++; $display("FAIL post_rst_writes got %0d want %0d", wrCount - w0, W * H); end
    ENABLE = 1'b0;
    drive_frame(0, NL, -1, 0, -1, -1);
  endtask

  task automatic test_drain();
    repeat (10) step();
    tests++;
    if (sbQ.size() != 0) begin failed++; $display("FAIL drain got %0d pending want 0", sbQ.size()); end
    tests++;
    if (doneCount != expDone) begin failed++; $display("FAIL done_total got %0d want %0d", doneCount, expDone); end
  endtask

  initial begin
    test_reset();
    test_full_frames();
    test_single_pixel();
    test_threshold();
    test_random();
    test_enable_drop();
    test_short_frame();
    test_line_err();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
